// File: rtl/pipe_phy_pkg.sv
// Shared encodings for the PIPE loopback PHY: PowerDown states, RxStatus codes and
// the per-lane control state.
package pipe_phy_pkg;

  localparam logic [3:0] PdP0  = 4'd0;
  localparam logic [3:0] PdP0s = 4'd1;
  localparam logic [3:0] PdP1  = 4'd2;
  localparam logic [3:0] PdP2  = 4'd3;

  localparam logic [2:0] RxStatOk       = 3'b000;
  localparam logic [2:0] RxStatDetected = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StDetect,
    StPwrChg,
    StRateChg
  } lane_state_e;

endpackage

// File: rtl/pipe_lane_delay.sv
// Fixed-depth shift register used as the per-lane Tx-to-Rx loopback path.
// All stages clear to zero on reset.
module pipe_lane_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pipe_loopback_phy.sv
// Behavioural PIPE PHY stand-in: loops Tx lanes back to Rx after a fixed delay and
// emulates receiver detect, power-state change and rate change handshakes.
module pipe_loopback_phy
  import pipe_phy_pkg::*;
#(
  parameter int unsigned LANESNUMBER   = 16,
  parameter int unsigned MAXPIPEWIDTH  = 32,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned SKEW_EN       = 0,
  parameter int unsigned DETECT_CYCLES = 4,
  parameter int unsigned RATE_CYCLES   = 6
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
  input  logic [LANESNUMBER-1:0]                TxDataValid,
  input  logic [LANESNUMBER-1:0]                TxElecIdle,
  input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]              PowerDown,
  input  logic [3:0]                            Rate,
  input  logic [LANESNUMBER-1:0]                det_present,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
  output logic [LANESNUMBER-1:0]                RxDataValid,
  output logic [LANESNUMBER-1:0]                RxValid,
  output logic [LANESNUMBER-1:0]                RxElectricalIdle,
  output logic [3*LANESNUMBER-1:0]              RxStatus,
  output logic [LANESNUMBER-1:0]                PhyStatus
);

  localparam int unsigned KW           = MAXPIPEWIDTH / 8;
  localparam int unsigned DW           = MAXPIPEWIDTH + KW + 3;
  localparam int unsigned PwrChgCycles = 2;
  localparam int unsigned CntMax       = (DETECT_CYCLES > RATE_CYCLES) ? DETECT_CYCLES
                                                                       : RATE_CYCLES;
  localparam int unsigned CntW         = $clog2(CntMax + 1);

  // Committed rate and the rate a running change is heading for; a new Rate value
  // while busy is judged against the target so the change restarts instead of
  // retriggering every cycle.
  logic [3:0]             rate_q, rate_tgt_q;
  logic                   rate_busy, rate_start, rate_done;
  logic [LANESNUMBER-1:0] lane_rate_busy, lane_rate_last;

  assign rate_busy  = lane_rate_busy[0];
  assign rate_start = rate_busy ? (Rate != rate_tgt_q) : (Rate != rate_q);
  assign rate_done  = lane_rate_last[0] & ~rate_start;

  always_ff @(posedge CLK) begin
    if (reset) begin
      rate_q     <= 4'd0;
      rate_tgt_q <= 4'd0;
    end else begin
      if (rate_start) rate_tgt_q <= Rate;
      if (rate_done)  rate_q     <= rate_tgt_q;
    end
  end

  for (genvar i = 0; i < LANESNUMBER; i++) begin : g_lane
    localparam int unsigned Depth = LATENCY + ((SKEW_EN != 0) ? (i % 4) : 0);

    lane_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pd_q, pd_d, pd_in;
    logic            det_q, det_rise, cnt_last;
    logic            phy_q, phy_d;
    logic [2:0]      rs_q, rs_d;
    logic [DW-1:0]   dly_in, dly_out;

    assign pd_in    = PowerDown[4*i +: 4];
    assign det_rise = TxDetectRx_Loopback[i] & ~det_q;
    assign cnt_last = (cnt_q <= CntW'(1));

    assign lane_rate_busy[i] = (state_q == StRateChg);
    assign lane_rate_last[i] = (state_q == StRateChg) && cnt_last;

    // An operation requested in cycle c completes with PhyStatus in cycle c+N.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pd_d    = pd_q;
      phy_d   = 1'b0;
      rs_d    = RxStatOk;
      if (rate_start) begin
        state_d = StRateChg;
        cnt_d   = CntW'(RATE_CYCLES - 1);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pd_in != pd_q) begin
              state_d = StPwrChg;
              cnt_d   = CntW'(PwrChgCycles - 1);
            end else if (det_rise && TxElecIdle[i] && (pd_in == PdP1)) begin
              state_d = StDetect;
              cnt_d   = CntW'(DETECT_CYCLES - 1);
            end
          end
          StDetect: begin
            if (cnt_last) begin
              state_d = StIdle;
              phy_d   = 1'b1;
              rs_d    = det_present[i] ? RxStatDetected : RxStatOk;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
          StPwrChg: begin
            if (cnt_last) begin
              state_d = StIdle;
              phy_d   = 1'b1;
              pd_d    = pd_in;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
          StRateChg: begin
            if (cnt_last) begin
              state_d = StIdle;
              phy_d   = 1'b1;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        pd_q    <= PdP1;
        det_q   <= 1'b0;
        phy_q   <= 1'b0;
        rs_q    <= RxStatOk;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pd_q    <= pd_d;
        det_q   <= TxDetectRx_Loopback[i];
        phy_q   <= phy_d;
        rs_q    <= rs_d;
      end
    end

    // Electrical idle travels inverted so the cleared delay line reads as idle.
    assign dly_in = {TxDataValid[i] & ~TxElecIdle[i], ~TxElecIdle[i], TxDataValid[i],
                     TxDataK[KW*i +: KW], TxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH]};

    pipe_lane_delay #(
      .WIDTH (DW),
      .DEPTH (Depth)
    ) u_delay (
      .clk   (CLK),
      .reset (reset),
      .din   (dly_in),
      .dout  (dly_out)
    );

    assign RxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH] = dly_out[MAXPIPEWIDTH-1:0];
    assign RxDataK[KW*i +: KW]                    = dly_out[MAXPIPEWIDTH +: KW];
    assign RxDataValid[i]                         = dly_out[MAXPIPEWIDTH+KW];
    assign RxElectricalIdle[i]                    = ~dly_out[MAXPIPEWIDTH+KW+1];
    assign RxValid[i]                             = dly_out[DW-1] & (state_q == StIdle);
    assign PhyStatus[i]                           = phy_q;
    assign RxStatus[3*i +: 3]                     = rs_q;
  end

endmodule
